// File: rtl/da_fir_pkg.sv
// da_fir_pkg: shared types, default widths and frame length helper for the DA-FIR bit-serial path
package da_fir_pkg;
   typedef enum logic {IDLE, SHIFT} ser_state_t;
   localparam int DA_W_DEF   = 16;
   localparam int DA_EXT_DEF = 2;
   function automatic int frame_len(input int w, input int ext);
      return w + ext;
   endfunction
endpackage

// File: rtl/da_ser_shreg.sv
// da_ser_shreg: L-bit right-shift register with parallel load (load wins over shift)
module da_ser_shreg #(
   parameter int L = 18
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic [L-1:0] i_data,
   output logic [L-1:0] o_q
);
   logic [L-1:0] r_q;
   // load a fresh frame or shift the current one toward bit 0
   always_ff @(posedge i_clk) begin
      if (i_rst) r_q <= '0;
      else if (i_load) r_q <= i_data;
      else if (i_shift) r_q <= r_q >> 1;
   end
   assign o_q = r_q;
endmodule

// File: rtl/da_bit_serializer.sv
// da_bit_serializer: LSB-first parallel-to-serial front end with sign/zero extension; DA_SER_PREFETCH_EN adds a one-sample hold register
module da_bit_serializer
   import da_fir_pkg::*;
#(
   parameter int W   = DA_W_DEF,
   parameter int EXT = DA_EXT_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_in_data,
   input  logic         i_in_signed,
   output logic         o_ser_bit,
   output logic         o_ser_valid,
   output logic         o_ser_first,
   output logic         o_ser_last,
   output logic         o_busy
);
   localparam int L  = frame_len(W, EXT);
   localparam int CW = $clog2(L);
   ser_state_t   r_state;
   logic [CW-1:0] r_cnt;
   logic         r_ser_bit, r_ser_valid, r_ser_first, r_ser_last;
   logic [L-1:0] w_sreg, w_new_data, w_load_data;
   logic         w_last, w_free, w_accept, w_load;
   // extension bits replicate the sample MSB only for signed samples
   always_comb begin
      w_new_data = {L{i_in_signed & i_in_data[W-1]}};
      w_new_data[W-1:0] = i_in_data;
   end
   assign w_last = (r_state == SHIFT) && (r_cnt == CW'(L-1));
   assign w_free = (r_state == IDLE) || w_last;
`ifdef DA_SER_PREFETCH_EN
   logic         r_hold_full;
   logic [L-1:0] r_hold_data;
   assign o_in_ready  = !r_hold_full;
   assign w_accept    = i_in_valid && !r_hold_full;
   assign w_load      = w_free && (r_hold_full || w_accept);
   assign w_load_data = r_hold_full ? r_hold_data : w_new_data;
   assign o_busy      = (r_state == SHIFT) || r_hold_full;
   // park a sample accepted mid-frame until the current frame ends
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_full <= 1'b0;
         r_hold_data <= '0;
      end else if (w_accept && !w_free) begin
         r_hold_full <= 1'b1;
         r_hold_data <= w_new_data;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end
   end
`else
   assign o_in_ready  = w_free;
   assign w_accept    = i_in_valid && w_free;
   assign w_load      = w_accept;
   assign w_load_data = w_new_data;
   assign o_busy      = (r_state == SHIFT);
`endif
   da_ser_shreg #(.L(L)) u_shreg (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load),
      .i_shift (r_state == SHIFT),
      .i_data  (w_load_data),
      .o_q     (w_sreg)
   );
   // frame FSM: registers the current bit with its markers and advances the bit counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_ser_bit   <= 1'b0;
         r_ser_valid <= 1'b0;
         r_ser_first <= 1'b0;
         r_ser_last  <= 1'b0;
      end else begin
         r_ser_bit   <= (r_state == SHIFT) && w_sreg[0];
         r_ser_valid <= (r_state == SHIFT);
         r_ser_first <= (r_state == SHIFT) && (r_cnt == '0);
         r_ser_last  <= w_last;
         if (w_load) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
         end else if (w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end else if (r_state == SHIFT) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
   assign o_ser_bit   = r_ser_bit;
   assign o_ser_valid = r_ser_valid;
   assign o_ser_first = r_ser_first;
   assign o_ser_last  = r_ser_last;
endmodule
